// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with pixel replication
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int SCALE    = 0,
    parameter int CNT_W    = 11,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [CNT_W-1:0]  x,
    output logic [CNT_W-1:0]  y,
    output logic [ADDR_W-1:0] addr,
    output logic              line_start,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SRC   = H_ACTIVE >> SCALE;
    localparam int V_SRC   = V_ACTIVE >> SCALE;

    generate
        if ((H_ACTIVE % (1 << SCALE)) != 0 || (V_ACTIVE % (1 << SCALE)) != 0) begin : g_bad_scale
            $error("active size not divisible by replication factor");
        end
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt
            $error("raster totals exceed counter width");
        end
        if (longint'(V_SRC) * longint'(H_SRC) > (longint'(1) << ADDR_W)) begin : g_bad_addr
            $error("frame buffer exceeds address width");
        end
    endgenerate

    // One extra bit so totals equal to 2^CNT_W still compare correctly.
    localparam logic [CNT_W:0] H_LAST = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic [CNT_W:0] H_ACT  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_LAST = (CNT_W+1)'(V_TOTAL - 1);
    localparam logic [CNT_W:0] V_ACT  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_SRC);
    localparam logic [CNT_W-1:0]  Y_SUB_MASK = CNT_W'((1 << SCALE) - 1);

    logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic              ls_q, ls_d, fs_q, fs_d;

    logic [CNT_W:0] h_ext, v_ext;
    logic           h_wrap, v_wrap, in_act;

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        row_d  = row_q;
        x_d    = x_q;
        y_d    = y_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        de_d   = de_q;
        addr_d = addr_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;

        h_ext  = {1'b0, h_q};
        v_ext  = {1'b0, v_q};
        h_wrap = (h_ext == H_LAST);
        v_wrap = (v_ext == V_LAST);
        in_act = (h_ext < H_ACT) && (v_ext < V_ACT);

        if (pix_en) begin
            x_d    = h_q;
            y_d    = v_q;
            de_d   = in_act;
            hs_d   = (h_ext >= HS_BEG && h_ext < HS_END) ? HS_POL : ~HS_POL;
            vs_d   = (v_ext >= VS_BEG && v_ext < VS_END) ? VS_POL : ~VS_POL;
            addr_d = in_act ? row_q + ADDR_W'(h_q >> SCALE) : '0;
            ls_d   = (h_q == '0);
            fs_d   = (h_q == '0) && (v_q == '0);

            if (h_wrap) begin
                h_d = '0;
                if (v_wrap) begin
                    v_d   = '0;
                    row_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                    // Row base moves on only after the last replica of a source line.
                    if (v_ext < V_ACT && (v_q & Y_SUB_MASK) == Y_SUB_MASK) begin
                        row_d = row_q + ROW_STEP;
                    end
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q    <= '0;
            v_q    <= '0;
            row_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            addr_q <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            row_q  <= row_d;
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            addr_q <= addr_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign addr        = addr_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of vga_timing_gen in several parameter modes
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en = 1'b0;
    logic pix_en4 = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // defaults
    logic d_hs, d_vs, d_de, d_ls, d_fs;
    logic [10:0] d_x, d_y;
    logic [18:0] d_addr;
    vga_timing_gen u_def (.clk(clk), .rst(rst), .pix_en(pix_en), .hs(d_hs), .vs(d_vs), .de(d_de),
        .x(d_x), .y(d_y), .addr(d_addr), .line_start(d_ls), .frame_start(d_fs));

    // inverted sync polarity
    logic p_hs, p_vs, p_de, p_ls, p_fs;
    logic [10:0] p_x, p_y;
    logic [18:0] p_addr;
    vga_timing_gen #(.HS_POL(1'b0), .VS_POL(1'b0)) u_pol (.clk(clk), .rst(rst), .pix_en(pix_en),
        .hs(p_hs), .vs(p_vs), .de(p_de), .x(p_x), .y(p_y), .addr(p_addr),
        .line_start(p_ls), .frame_start(p_fs));

    // default sizes, 2x replication
    logic c_hs, c_vs, c_de, c_ls, c_fs;
    logic [10:0] c_x, c_y;
    logic [18:0] c_addr;
    vga_timing_gen #(.SCALE(1)) u_sc (.clk(clk), .rst(rst), .pix_en(pix_en), .hs(c_hs), .vs(c_vs),
        .de(c_de), .x(c_x), .y(c_y), .addr(c_addr), .line_start(c_ls), .frame_start(c_fs));

    // small raster 24x12 so whole frames fit the run
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic [5:0] s_x, s_y;
    logic [6:0] s_addr;
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(8), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .CNT_W(6), .ADDR_W(7)) u_sm (.clk(clk), .rst(rst), .pix_en(pix_en),
        .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y), .addr(s_addr),
        .line_start(s_ls), .frame_start(s_fs));

    logic t_hs, t_vs, t_de, t_ls, t_fs;
    logic [5:0] t_x, t_y;
    logic [4:0] t_addr;
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(8), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .SCALE(1), .CNT_W(6), .ADDR_W(5)) u_sms (.clk(clk), .rst(rst),
        .pix_en(pix_en), .hs(t_hs), .vs(t_vs), .de(t_de), .x(t_x), .y(t_y), .addr(t_addr),
        .line_start(t_ls), .frame_start(t_fs));

    // defaults, pixel enable every 4th clock
    logic v_hs, v_vs, v_de, v_ls, v_fs;
    logic [10:0] v_x, v_y;
    logic [18:0] v_addr;
    vga_timing_gen u_div (.clk(clk), .rst(rst), .pix_en(pix_en4), .hs(v_hs), .vs(v_vs), .de(v_de),
        .x(v_x), .y(v_y), .addr(v_addr), .line_start(v_ls), .frame_start(v_fs));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    initial begin : gen_div
        int dc;
        dc = 0;
        forever begin
            @(posedge clk);
            #2;
            dc++;
            pix_en4 = (dc % 4 == 0);
        end
    end

    initial begin : main
        int n_cyc;
        int ex, ey, sx, sy;
        int ede, sde;
        int err_def, err_pol, err_sc, err_sm, err_sms;
        int de_cnt0, hs_rise_x, hs_fall_x, ls_cnt, ls_first_gap, ls_prev_k;
        int fs_small_gap, fs_small_prev, vs_small_cnt;
        logic prev_hs;
        logic found, pe;
        int prev_x, last_change, hold_err, ls_long_err, ls_n;
        int ls_pos[4];
        logic prev_ls;

        err_def = 0; err_pol = 0; err_sc = 0; err_sm = 0; err_sms = 0;
        de_cnt0 = 0; hs_rise_x = -1; hs_fall_x = -1; ls_cnt = 0; ls_first_gap = -1; ls_prev_k = -1;
        fs_small_gap = -1; fs_small_prev = -1; vs_small_cnt = 0;
        prev_hs = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_hs", d_hs, 0);
        check_val("rst_vs", d_vs, 0);
        check_val("rst_de", d_de, 0);
        check_val("rst_pol_hs", p_hs, 1);
        check_val("rst_pol_vs", p_vs, 1);

        rst = 1'b1;
        pix_en = 1'b1;
        n_cyc = 3 * 1056 + 12;
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            ex = k % 1056;
            ey = k / 1056;
            ede = (ex < 800 && ey < 600) ? 1 : 0;
            if (d_x !== 11'(ex) || d_y !== 11'(ey) || d_de !== 1'(ede)
                || d_addr !== 19'(ede != 0 ? ey * 800 + ex : 0)
                || d_hs !== 1'(ex >= 840 && ex < 968) || d_vs !== 1'b0
                || d_ls !== 1'(ex == 0) || d_fs !== 1'(ex == 0 && ey == 0))
                err_def++;
            if (p_x !== 11'(ex) || p_de !== 1'(ede) || p_hs !== 1'(!(ex >= 840 && ex < 968))
                || p_vs !== 1'b1)
                err_pol++;
            if (c_x !== 11'(ex) || c_y !== 11'(ey) || c_de !== 1'(ede)
                || c_addr !== 19'(ede != 0 ? (ey / 2) * 400 + ex / 2 : 0))
                err_sc++;

            sx = k % 24;
            sy = (k / 24) % 12;
            sde = (sx < 16 && sy < 8) ? 1 : 0;
            if (s_x !== 6'(sx) || s_y !== 6'(sy) || s_de !== 1'(sde)
                || s_addr !== 7'(sde != 0 ? sy * 16 + sx : 0)
                || s_hs !== 1'(sx >= 18 && sx < 22) || s_vs !== 1'(sy >= 9 && sy < 11)
                || s_ls !== 1'(sx == 0) || s_fs !== 1'(sx == 0 && sy == 0))
                err_sm++;
            if (t_x !== 6'(sx) || t_y !== 6'(sy) || t_de !== 1'(sde)
                || t_addr !== 5'(sde != 0 ? (sy / 2) * 8 + sx / 2 : 0))
                err_sms++;

            if (k < 1056 && d_de === 1'b1) de_cnt0++;
            if (k < 1056 && d_hs === 1'b1 && prev_hs === 1'b0 && hs_rise_x < 0) hs_rise_x = int'(d_x);
            if (k < 1056 && d_hs === 1'b0 && prev_hs === 1'b1 && hs_fall_x < 0) hs_fall_x = int'(d_x);
            prev_hs = d_hs;
            if (d_ls === 1'b1) begin
                ls_cnt++;
                if (ls_prev_k >= 0 && ls_first_gap < 0) ls_first_gap = k - ls_prev_k;
                ls_prev_k = k;
            end
            if (s_fs === 1'b1) begin
                if (fs_small_prev >= 0 && fs_small_gap < 0) fs_small_gap = k - fs_small_prev;
                fs_small_prev = k;
            end
            if (k < 288 && s_vs === 1'b1) vs_small_cnt++;

            if (k == 0) begin
                check_val("first_x", d_x, 0);
                check_val("first_y", d_y, 0);
                check_val("first_de", d_de, 1);
                check_val("first_addr", d_addr, 0);
                check_val("first_fs", d_fs, 1);
                check_val("first_ls", d_ls, 1);
            end
            if (k == 799) check_val("addr_799_0", d_addr, 799);
            if (k == 800) check_val("de_off_800", d_de, 0);
            if (k == 839) check_val("pol_hs_idle", p_hs, 1);
            if (k == 840) check_val("pol_hs_pulse", p_hs, 0);
            if (k == 3 * 1056 + 5) check_val("sc_addr_5_3", c_addr, 402);
            if (k == 3 * 1056 + 6) check_val("sc_addr_6_3", c_addr, 403);
            if (k == 7 * 24 + 15) begin
                check_val("sm_addr_last", s_addr, 127);
                check_val("sms_addr_last", t_addr, 31);
            end
            if (k == 288) begin
                check_val("sm_wrap_x", s_x, 0);
                check_val("sm_wrap_y", s_y, 0);
                check_val("sm_wrap_addr", s_addr, 0);
                check_val("sm_wrap_fs", s_fs, 1);
            end
        end
        check_val("def_raster_err", err_def, 0);
        check_val("pol_raster_err", err_pol, 0);
        check_val("sc_raster_err", err_sc, 0);
        check_val("sm_raster_err", err_sm, 0);
        check_val("sms_raster_err", err_sms, 0);
        check_val("de_count_line0", de_cnt0, 800);
        check_val("hs_rise_x", hs_rise_x, 840);
        check_val("hs_fall_x", hs_fall_x, 968);
        check_val("ls_count", ls_cnt, 4);
        check_val("ls_period", ls_first_gap, 1056);
        check_val("sm_frame_period", fs_small_gap, 288);
        check_val("sm_vs_cycles", vs_small_cnt, 48);

        // asynchronous reset in the middle of a line
        rst = 1'b0;
        #1;
        check_val("arst_hs", d_hs, 0);
        check_val("arst_vs", d_vs, 0);
        check_val("arst_de", d_de, 0);
        check_val("arst_addr", d_addr, 0);
        check_val("arst_ls", d_ls, 0);
        check_val("arst_fs", d_fs, 0);
        check_val("arst_pol_hs", p_hs, 1);
        check_val("arst_div_de", v_de, 0);
        repeat (3) @(negedge clk);
        check_val("rst_hold_x", v_x, 0);
        rst = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            pe = pix_en4;
            @(negedge clk);
            if (pe) found = 1'b1;
            else check_val("div_pre_fs", v_fs, 0);
        end
        check_val("div_found_edge", found, 1);
        check_val("div_first_x", v_x, 0);
        check_val("div_first_y", v_y, 0);
        check_val("div_first_fs", v_fs, 1);
        check_val("div_first_de", v_de, 1);

        prev_x = 0; last_change = 0; hold_err = 0; ls_long_err = 0; ls_n = 1;
        ls_pos[0] = 0; ls_pos[1] = -1; ls_pos[2] = -1; ls_pos[3] = -1;
        prev_ls = v_ls;
        for (int c = 1; c < 9000; c++) begin
            @(negedge clk);
            if (int'(v_x) != prev_x) begin
                if (c - last_change != 4) hold_err++;
                last_change = c;
                prev_x = int'(v_x);
            end
            if (v_ls === 1'b1) begin
                if (prev_ls === 1'b1) ls_long_err++;
                else if (ls_n < 4) begin
                    ls_pos[ls_n] = c;
                    ls_n++;
                end
            end
            if (v_fs === 1'b1 && c < 4224 * 2) hold_err++;
            prev_ls = v_ls;
        end
        check_val("div_hold_err", hold_err, 0);
        check_val("div_ls_width_err", ls_long_err, 0);
        check_val("div_line_period", ls_pos[1] - ls_pos[0], 4224);
        check_val("div_line_period2", ls_pos[2] - ls_pos[1], 4224);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the successor to the fixed 800x600 timing block. It produces sync, data-enable, pixel coordinates and a linear frame-buffer address for any mode that fits its counter widths. It adds a pixel-clock enable for divided pixel rates, selectable sync polarity, line/frame start strobes and integer pixel replication (2^SCALE) for low-resolution frame buffers. It sits between the system clock domain and the pixel ROM/RAM read port and VGA pins.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hs asserted level (1 = active-high)
- VS_POL, 1, vs asserted level
- SCALE, 0, log2 pixel replication factor in x and y
- CNT_W, 11, width of x/y counters
- ADDR_W, 19, frame-buffer address width
- clk  in  1  system clock; the block has one clock
- rst  in  1  reset, asynchronous, active-low
- pix_en  in  1  pixel advance enable; tie to 1 when clk is the pixel clock
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  data enable: high inside the active area
- x  out  CNT_W  horizontal count, 0..H_TOTAL-1
- y  out  CNT_W  vertical count, 0..V_TOTAL-1
- addr  out  ADDR_W  source pixel address; 0 when de=0
- line_start  out  1  one-clk pulse when x=0
- frame_start  out  1  one-clk pulse when x=0 and y=0

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
- Elaboration fails in any of these cases:
  - H_ACTIVE or V_ACTIVE is not divisible by 2^SCALE.
  - H_TOTAL or V_TOTAL exceeds 2^CNT_W.
  - (V_ACTIVE>>SCALE)*(H_ACTIVE>>SCALE) exceeds 2^ADDR_W.
- Internal counters h,v:
  - On each clk edge with pix_en=1, h increments.
  - At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At v=V_TOTAL-1 with that wrap, v wraps to 0.
  - With pix_en=0, the counters and all non-pulse outputs hold.
- Line layout: the active region comes first.
  - de = (h<H_ACTIVE) and (v<V_ACTIVE).
  - hs is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs is asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - The asserted level is the POL parameter; the deasserted level is its inverse.
- Address:
  - When de=1, addr = (y>>SCALE)*(H_ACTIVE>>SCALE) + (x>>SCALE).
  - It is generated incrementally, with no multiplier: a row-base register advances by H_ACTIVE>>SCALE at the end of every 2^SCALE-th active line and clears at frame wrap.
  - When de=0, addr = 0.
- Outputs:
  - x, y, hs, vs, de and addr are registered and all describe the same (h,v) point.
  - line_start/frame_start are single-clk pulses, even when pix_en is sparse. They are cleared on the next clk regardless of pix_en.
- Reset (asynchronous assert; release takes effect on the next clk edge):
  - h=v=0, row base 0.
  - x=y=0, addr=0, de=0, line_start=frame_start=0.
  - hs=~HS_POL, vs=~VS_POL.
- Reset mid-frame aborts the frame. The frame restarts from (0,0), and frame_start fires on the first pix_en cycle after release.

## Timing
- Latency: outputs change on the clk edge of the pix_en cycle.
  - The first pix_en=1 edge after reset release presents (x,y)=(0,0) with de=1, addr=0, line_start=1 and frame_start=1.
  - Each subsequent pix_en edge presents the next raster point.
- Line period: H_TOTAL pix_en cycles. Frame period: H_TOTAL*V_TOTAL pix_en cycles (663168 by default).
- With pix_en=1 continuously, hs is asserted for exactly H_SYNC consecutive clk cycles per line, and vs for exactly V_SYNC*H_TOTAL cycles per frame.
- The address steps by at most 1 per pix_en cycle, with no bubbles across line wrap.

## Test plan
- **Reset values:** assert rst=0 mid-line with pix_en toggling -> required response:
  - hs=0, vs=0, de=0, addr=0 and both pulses low, immediately (asynchronously).
  - After release, the first pix_en edge gives x=0, y=0, frame_start=1.
- **Default line timing, pix_en=1:**
  - de is high for 800 cycles.
  - hs rises at x=840 and falls at x=968.
  - line_start recurs every 1056 cycles.
  - addr at (799,0) = 799.
- **Frame wrap:**
  - vs is high for lines 601..604.
  - addr at (799,599) = 479999.
  - The next cycle gives x=0, y=0, addr=0, frame_start=1.
  - 663168 cycles elapse between frame_start pulses.
- **SCALE=1 at defaults:**
  - addr at (5,3) = 402.
  - addr at (799,599) = 119999.
  - The address holds for 2 consecutive pixels and repeats for each line pair.
- **pix_en=1 every 4th clk:**
  - Each output holds for 4 clks.
  - line_start is high for exactly 1 clk.
  - The line period is 4224 clks.
- **HS_POL=0, VS_POL=0:** hs and vs idle high and pulse low with the same windows as the default line/frame tests.
